// File: rtl/wi23_defs.sv
// wi23_defs: shared definitions for the wi23 CPU register file.
//   REGFILE_WIDTH : default data width in bits
//   REGFILE_DEPTH : default address width (entries = 1 << REGFILE_DEPTH)
//   rf_state_t    : register-file sequencer state (clearing / running)
package wi23_defs;
  localparam int REGFILE_WIDTH = 32;
  localparam int REGFILE_DEPTH = 5;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;
endpackage

// File: rtl/rf_bank.sv
// rf_bank: one 1W1R synchronous RAM bank with registered, enabled read.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata holds when low
//   raddr : read address
//   rdata : registered read data (old contents on read-during-write)
// The bank has no reset so that it maps onto a block RAM.
module rf_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam int ENTRIES = 1 << DEPTH;

  (* ramstyle = "m10k" *) logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rf_nport.sv
// rf_nport: NUM_READ-port / 1-write register file with one-cycle registered
// reads, internal write-to-read bypass and a power-on clear sequencer.
// Ports:
//   clk         : sole clock, rising edge
//   rst_n       : synchronous active-low reset (restarts the clear sequence)
//   rd_en       : per-port read enable
//   readregsel  : packed read addresses, port p at [p*DEPTH +: DEPTH]
//   writeregsel : write address
//   writedata   : write data
//   write       : write strobe
//   readdata    : packed registered read data, port p at [p*WIDTH +: WIDTH]
//   ready       : high once every entry has been cleared
//   err         : one-cycle pulse when a user write is dropped during clear
// Build option: define RF_ZERO_REG_EN to hardwire entry 0 to zero.
module rf_nport
  import wi23_defs::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int NUM_READ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_READ-1:0]       rd_en,
  input  logic [NUM_READ*DEPTH-1:0] readregsel,
  input  logic [DEPTH-1:0]          writeregsel,
  input  logic [WIDTH-1:0]          writedata,
  input  logic                      write,
  output logic [NUM_READ*WIDTH-1:0] readdata,
  output logic                      ready,
  output logic                      err
);
  localparam int ENTRIES = 1 << DEPTH;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  rf_state_t        state_q, state_d;
  logic [DEPTH-1:0] clr_cnt_q;
  logic             ready_q, err_q;
  logic             clearing, clear_done;

  assign clearing   = (state_q == RF_CLEAR);
  assign clear_done = (clr_cnt_q == DEPTH'(ENTRIES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RF_CLEAR: if (clear_done) state_d = RF_RUN;
      RF_RUN:   state_d = RF_RUN;
      default:  state_d = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clearing) clr_cnt_q <= clr_cnt_q + 1'b1;
      ready_q <= (state_d == RF_RUN);
      err_q   <= clearing && write;
    end
  end

  assign ready = ready_q;
  assign err   = err_q;

  // Shared write port: the clear sequencer owns it until RUN. User writes to
  // a hardwired-zero entry are dropped without flagging an error.
  logic             wr_zero_drop;
  logic             bank_we;
  logic [DEPTH-1:0] bank_waddr;
  logic [WIDTH-1:0] bank_wdata;

  assign wr_zero_drop = ZERO_REG && (writeregsel == '0);
  assign bank_we      = rst_n && (clearing || (write && !wr_zero_drop));
  assign bank_waddr   = clearing ? clr_cnt_q : writeregsel;
  assign bank_wdata   = clearing ? '0 : writedata;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [DEPTH-1:0] raddr;
    logic             rd_fire;
    logic             byp_now;
    logic [WIDTH-1:0] bank_q_p1;
    logic             byp_hit_p1;
    logic             zero_p1;
    logic [WIDTH-1:0] byp_data_p1;

    assign raddr   = readregsel[p*DEPTH +: DEPTH];
    assign rd_fire = rd_en[p] && !clearing;
    assign byp_now = write && (writeregsel == raddr);

    rf_bank #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_bank (
      .clk  (clk),
      .we   (bank_we),
      .waddr(bank_waddr),
      .wdata(bank_wdata),
      .re   (rd_fire),
      .raddr(raddr),
      .rdata(bank_q_p1)
    );

    // ---- stage p1: output select flags registered alongside the RAM read
    // zero_p1 forces 0 while clearing, after reset, and for reads of a
    // hardwired-zero entry (which also covers the bypass case there).
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        byp_hit_p1 <= 1'b0;
        zero_p1    <= 1'b1;
      end else if (clearing) begin
        byp_hit_p1 <= 1'b0;
        zero_p1    <= 1'b1;
      end else if (rd_en[p]) begin
        byp_hit_p1 <= byp_now;
        zero_p1    <= ZERO_REG && (raddr == '0);
      end
    end

    // Per-port copy so a held port keeps its own bypassed value.
    always_ff @(posedge clk) begin
      if (rd_fire && byp_now) byp_data_p1 <= writedata;
    end

    assign readdata[p*WIDTH +: WIDTH] = zero_p1    ? '0          :
                                        byp_hit_p1 ? byp_data_p1 : bank_q_p1;
  end
endmodule

// File: tb/tb_rf_nport.sv
module tb_rf_nport;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int NR    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NR-1:0]        rd_en;
  logic [NR*DEPTH-1:0]  readregsel;
  logic [DEPTH-1:0]     writeregsel;
  logic [WIDTH-1:0]     writedata;
  logic                 write;
  logic [NR*WIDTH-1:0]  readdata;
  logic                 ready;
  logic                 err;

  int n_vec  = 0;
  int n_fail = 0;

  rf_nport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_READ(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .readregsel (readregsel),
    .writeregsel(writeregsel),
    .writedata  (writedata),
    .write      (write),
    .readdata   (readdata),
    .ready      (ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vt[13];

`ifdef RF_ZERO_REG_EN
  localparam logic [31:0] R0_FF = 32'h0;
  localparam logic [31:0] R0_12 = 32'h0;
`else
  localparam logic [31:0] R0_FF = 32'hFF;
  localparam logic [31:0] R0_12 = 32'h12;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rd(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
    rd_en      = re;
    readregsel = {a1, a0};
  endtask

  // Releases reset and walks the clear; optionally injects a write at edge 10.
  task automatic run_clear(input bit inject);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (inject && k == 10) begin
        write = 1'b1; writeregsel = 5'd9; writedata = 32'hFFFF_FFFF;
      end else begin
        write = 1'b0;
      end
      tick();
      check($sformatf("ready_edge%0d", k), {31'd0, ready}, {31'd0, (k >= 32)});
      if (inject && k == 10) check("err_pulse", {31'd0, err}, 32'd1);
      if (inject && k == 11) check("err_clear", {31'd0, err}, 32'd0);
      if (k == 20) begin
        check("clear_rd0", readdata[31:0], 32'h0);
        check("clear_rd1", readdata[63:32], 32'h0);
      end
    end
    write = 1'b0;
  endtask

  initial begin
    //            we  wa     wd             re     ra0    ra1    exp0           exp1
    vt[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 2'b00, 5'd7, 5'd7, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 5'd4, 32'h55,       2'b00, 5'd0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 5'd3, 32'h1234,     2'b11, 5'd3, 5'd4, 32'h1234,     32'h55};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd7, 5'd3, 32'hDEADBEEF, 32'h55};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd4, 5'd7, 32'h55,       32'h55};
    vt[6]  = '{1'b1, 5'd4, 32'hAAAA,     2'b11, 5'd4, 5'd4, 32'hAAAA,     32'hAAAA};
    vt[7]  = '{1'b1, 5'd5, 32'h77,       2'b10, 5'd3, 5'd5, 32'hAAAA,     32'h77};
    vt[8]  = '{1'b1, 5'd6, 32'h6,        2'b00, 5'd6, 5'd6, 32'hAAAA,     32'h77};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd6, 5'd3, 32'h6,        32'h1234};
    vt[10] = '{1'b1, 5'd0, 32'hFF,       2'b00, 5'd0, 5'd0, 32'h6,        32'h1234};
    vt[11] = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd0, 5'd0, R0_FF,        R0_FF};
    vt[12] = '{1'b1, 5'd0, 32'h12,       2'b11, 5'd0, 5'd7, R0_12,        32'hDEADBEEF};

    rst_n = 1'b0; write = 1'b0; writeregsel = '0; writedata = '0;
    set_rd(2'b11, 5'd1, 5'd2);
    tick(); tick();
    check("rst_rd0",   readdata[31:0],  32'h0);
    check("rst_rd1",   readdata[63:32], 32'h0);
    check("rst_ready", {31'd0, ready},  32'd0);
    check("rst_err",   {31'd0, err},    32'd0);

    run_clear(1'b1);

    for (int a = 0; a < 32; a++) begin
      set_rd(2'b11, 5'(a), 5'(31 - a));
      tick();
      check($sformatf("zero_p0_r%0d", a), readdata[31:0], 32'h0);
      check($sformatf("zero_p1_r%0d", 31 - a), readdata[63:32], 32'h0);
    end

    for (int i = 0; i < 13; i++) begin
      write = vt[i].we; writeregsel = vt[i].wa; writedata = vt[i].wd;
      set_rd(vt[i].re, vt[i].ra0, vt[i].ra1);
      tick();
      check($sformatf("vec%0d_p0", i), readdata[31:0],  vt[i].exp0);
      check($sformatf("vec%0d_p1", i), readdata[63:32], vt[i].exp1);
      check($sformatf("vec%0d_err", i), {31'd0, err},   32'd0);
    end
    write = 1'b0;

    // Mid-operation reset: ready drops, contents are cleared again.
    rst_n = 1'b0;
    set_rd(2'b11, 5'd7, 5'd3);
    tick();
    check("rerst_ready", {31'd0, ready},  32'd0);
    check("rerst_rd0",   readdata[31:0],  32'h0);
    run_clear(1'b0);
    set_rd(2'b11, 5'd7, 5'd3);
    tick();
    check("reclr_r7", readdata[31:0],  32'h0);
    check("reclr_r3", readdata[63:32], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_nport.md
# rf_nport

Parametrised multi-read-port register file for the wi23 CPU, successor to the 2-read/1-write negedge register file. It runs on the rising edge with a one-cycle registered read and an internal write-to-read bypass, so the decode stage no longer needs external bypass muxes. A power-on clear sequencer zeroes every entry through the write path, which keeps all storage M10K-inferable. Sits between decode (read) and writeback (write).

## Interface
- `WIDTH`, default `REGFILE_WIDTH`: data width in bits.
- `DEPTH`, default `REGFILE_DEPTH`: address width; `ENTRIES = 1 << DEPTH`.
- `NUM_READ`, default 2: number of independent read ports, minimum 1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rd_en`  in  NUM_READ  per-port read enable.
- `readregsel`  in  NUM_READ*DEPTH  packed read addresses, port p at `[p*DEPTH +: DEPTH]`.
- `writeregsel`  in  DEPTH  write address.
- `writedata`  in  WIDTH  write data.
- `write`  in  1  write strobe.
- `readdata`  out  NUM_READ*WIDTH  packed registered read data.
- `ready`  out  1  high once the clear sequence is complete.
- `err`  out  1  one-cycle pulse when a write is dropped.

## Operation
- States are `CLEAR` and `RUN`. A clock edge with `rst_n` low forces the following:
  - `CLEAR`, `clr_cnt=0`, `readdata=0`, `ready=0`, `err=0`.
- `CLEAR`: on each edge with `rst_n` high, write 0 to entry `clr_cnt` in every bank, then increment `clr_cnt`.
  - On the edge that writes entry `ENTRIES-1`, go to `RUN` and set `ready=1`.
  - User writes are ignored. If `write` is high, `err` is 1 on the next cycle.
  - `readdata` is held at 0.
- `RUN`: if `write` is high, store `writedata` at `writeregsel` in all NUM_READ bank copies.
- Read port p in `RUN`:
  - `rd_en[p]=1`: `readdata[p]` gets the entry at `readregsel[p]` on the next edge.
  - `rd_en[p]=0`: `readdata[p]` holds its value.
- Bypass: if `write`, `rd_en[p]`, and `writeregsel==readregsel[p]` are all high in the same cycle, `readdata[p]` gets `writedata`, never the stale entry.
- Any number of ports may read the same address in the same cycle. All of them get the same value, bypassed where applicable.
- `err` is a pulse, not sticky.
- Reset mid-clear or mid-operation restarts the clear from entry 0. Previous contents are treated as lost.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and data is valid after edge N.
- Write is visible to a read addressed at the same edge through the bypass, and to any later read from the array.
- Clear takes exactly `ENTRIES` cycles. `ready` rises after the `ENTRIES`-th edge with `rst_n` high; for DEPTH=5 that is edge 32.
- Reset values: `readdata=0`, `ready=0`, `err=0`.
- No combinational path from any input to any output.

## Configuration
- `RF_ZERO_REG_EN` defined: entry 0 is hardwired to zero.
  - Writes to address 0 are silently dropped; no `err`.
  - Reads of address 0 return 0, including in the bypass case.
- `RF_ZERO_REG_EN` undefined: entry 0 is an ordinary register.

## Structure
- `wi23_defs` holds `REGFILE_WIDTH`, `REGFILE_DEPTH`, and a new `rf_state_t` enum (`RF_CLEAR`, `RF_RUN`).
- Sub-module `rf_bank`: one 1W1R synchronous RAM.
  - Write port, registered read, and read enable.
  - Carries the `ramstyle = "m10k"` attribute.
  - Instantiated NUM_READ times, all sharing one write port muxed between the clear sequencer and the user write.
- The bypass compare/mux per port and the sequencer live in `rf_nport`.

## Test plan
- Reset, DEPTH=5, NUM_READ=2: `ready` is 0 for 31 edges and goes to 1 at edge 32. Reading every address afterward returns 0.
- `RUN`: write 0xDEADBEEF to r7, then read r7 on both ports next cycle: both ports show 0xDEADBEEF one cycle later.
- Same-cycle write 0x1234 to r3 with port 0 reading r3 and port 1 reading r4 (r4 holds 0x55): port 0 gives 0x1234, port 1 gives 0x55.
- Port 1 `rd_en=0` while the address changes: `readdata[1]` holds its old value. Port 0 keeps updating.
- `write=1` during `CLEAR` (cycle 10): `err` is 1 for exactly one cycle and the entry still reads 0 after `ready`.
- With `RF_ZERO_REG_EN`: write 0xFF to r0 → r0 reads 0 and `err` stays 0. Without the macro, r0 reads 0xFF. Also assert `rst_n` mid-operation, check that `ready` drops and r7 reads 0 after the re-clear.
